// File: rtl/transform_sequencer.sv
// rtl/transform_sequencer.sv - sequences vertex RAM reads through the transform datapath into result RAM
module transform_sequencer #(
    parameter int AW     = 8,
    parameter int DP_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW:0]   count,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [15:0]   cfg_wdata,
    output logic          cfg_reject,
    output logic          vmem_rd_en,
    output logic [AW-1:0] vmem_addr,
    input  logic [47:0]   vmem_rdata,
    output logic [15:0]   dp_v1,
    output logic [15:0]   dp_v2,
    output logic [15:0]   dp_v3,
    output logic [15:0]   dp_cos_a,
    output logic [15:0]   dp_sin_a,
    output logic [15:0]   dp_cos_b,
    output logic [15:0]   dp_sin_b,
    output logic [15:0]   dp_cos_g,
    output logic [15:0]   dp_sin_g,
    output logic [15:0]   dp_dx,
    output logic [15:0]   dp_dy,
    output logic [15:0]   dp_dz,
    input  logic [15:0]   dp_result,
    output logic          rmem_we,
    output logic [AW-1:0] rmem_addr,
    output logic [15:0]   rmem_wdata,
    output logic          busy,
    output logic          done,
    output logic          aborted
);
    localparam int WW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LOAD, S_WAIT, S_WR, S_DONE} state_t;

    state_t        state;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   idx;
    logic [WW-1:0] wcnt;
    logic          we_q;
    logic [15:0]   cfg_r [9];

    // Write strobe is gated so an abort landing in the WR cycle kills that write.
    assign rmem_we = we_q & ~abort;

    assign dp_cos_a = cfg_r[0];
    assign dp_sin_a = cfg_r[1];
    assign dp_cos_b = cfg_r[2];
    assign dp_sin_b = cfg_r[3];
    assign dp_cos_g = cfg_r[4];
    assign dp_sin_g = cfg_r[5];
    assign dp_dx    = cfg_r[6];
    assign dp_dy    = cfg_r[7];
    assign dp_dz    = cfg_r[8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            idx        <= '0;
            wcnt       <= '0;
            we_q       <= 1'b0;
            cfg_reject <= 1'b0;
            vmem_rd_en <= 1'b0;
            vmem_addr  <= '0;
            dp_v1      <= '0;
            dp_v2      <= '0;
            dp_v3      <= '0;
            rmem_addr  <= '0;
            rmem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                cfg_r[k] <= (k == 0 || k == 2 || k == 4) ? 16'd1 : 16'd0;
            end
        end else begin
            vmem_rd_en <= 1'b0;
            we_q       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            cfg_reject <= 1'b0;

            // Config is only writable between jobs so a running job sees frozen parameters.
            if (cfg_we) begin
                if (state == S_IDLE) begin
                    if (cfg_addr < 4'd9) cfg_r[cfg_addr] <= cfg_wdata;
                end else begin
                    cfg_reject <= 1'b1;
                end
            end

            if (abort && state != S_IDLE) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        src_q <= src_base;
                        dst_q <= dst_base;
                        cnt_q <= count;
                        idx   <= '0;
                        busy  <= 1'b1;
                        if (count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= S_RD;
                            vmem_rd_en <= 1'b1;
                            vmem_addr  <= src_base;
                        end
                    end
                    S_RD: state <= S_LOAD;
                    S_LOAD: begin
                        dp_v1 <= vmem_rdata[47:32];
                        dp_v2 <= vmem_rdata[31:16];
                        dp_v3 <= vmem_rdata[15:0];
                        wcnt  <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wcnt == WW'(DP_LAT - 1)) begin
                            state      <= S_WR;
                            we_q       <= 1'b1;
                            rmem_addr  <= dst_q + idx[AW-1:0];
                            rmem_wdata <= dp_result;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                    S_WR: begin
                        idx <= idx + 1'b1;
                        if (idx + 1'b1 == cnt_q) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= S_RD;
                            vmem_rd_en <= 1'b1;
                            vmem_addr  <= src_q + idx[AW-1:0] + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
